// File: rtl/timer_multi_pkg.sv
// timer_multi_pkg: register offsets and CTRL/STATUS bit positions shared by the multi-channel APB timer
package timer_multi_pkg;
    localparam logic [8:0] REG_COUNT  = 9'h000;
    localparam logic [8:0] REG_CTRL   = 9'h004;
    localparam logic [8:0] REG_CMP    = 9'h008;
    localparam logic [8:0] REG_STATUS = 9'h00C;
    localparam logic [8:0] REG_START  = 9'h100;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_CMP_IE  = 2;
    localparam int CTRL_OVF_IE  = 3;
    localparam int CTRL_PRESC   = 8;
    localparam int ST_CMP       = 0;
    localparam int ST_OVF       = 1;
endpackage

// File: rtl/timer_multi_channel.sv
// timer_multi_channel: one timer channel (write strobes/wdata/start in; register read values and registered irq out)
module timer_multi_channel
    import timer_multi_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_ctrl,
    input  logic        wr_cmp,
    input  logic        wr_status,
    input  logic        start,
    input  logic [31:0] wdata,
    output logic [31:0] count_rd,
    output logic [31:0] ctrl_rd,
    output logic [31:0] cmp_rd,
    output logic [31:0] status_rd,
    output logic        irq
);
    logic [CNT_WIDTH-1:0]   count, cmp, count_n;
    logic [PRESC_WIDTH-1:0] presc, pcnt, pcnt_n;
    logic en, oneshot, cmp_ie, ovf_ie, cmp_pend, ovf_pend;
    logic en_n, cmp_ie_n, ovf_ie_n, cmp_pend_n, ovf_pend_n;
    logic tick, cmp_hit, ovf_hit, fire;
    logic unused_wdata;
    assign tick    = en && pcnt == presc;
    assign cmp_hit = tick && cmp != '0 && count == cmp;
    assign ovf_hit = tick && !cmp_hit && (&count);
    assign fire    = cmp_hit || ovf_hit;
    assign unused_wdata = ^wdata;
    always_comb begin
        count_n    = wr_count ? wdata[CNT_WIDTH-1:0] : (wr_cmp || fire) ? '0 : tick ? count + CNT_WIDTH'(1) : count;
        pcnt_n     = (!en || tick || wr_count || wr_cmp || wr_ctrl) ? '0 : pcnt + PRESC_WIDTH'(1);
        en_n       = wr_ctrl ? wdata[CTRL_EN] : start ? 1'b1 : (fire && oneshot) ? 1'b0 : en;
        cmp_ie_n   = wr_ctrl ? wdata[CTRL_CMP_IE] : cmp_ie;
        ovf_ie_n   = wr_ctrl ? wdata[CTRL_OVF_IE] : ovf_ie;
        cmp_pend_n = cmp_hit || (cmp_pend && !(wr_status && wdata[ST_CMP]));
        ovf_pend_n = ovf_hit || (ovf_pend && !(wr_status && wdata[ST_OVF]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            cmp      <= '0;
            pcnt     <= '0;
            presc    <= '0;
            en       <= 1'b0;
            oneshot  <= 1'b0;
            cmp_ie   <= 1'b0;
            ovf_ie   <= 1'b0;
            cmp_pend <= 1'b0;
            ovf_pend <= 1'b0;
            irq      <= 1'b0;
        end else begin
            count    <= count_n;
            cmp      <= wr_cmp ? wdata[CNT_WIDTH-1:0] : cmp;
            pcnt     <= pcnt_n;
            presc    <= wr_ctrl ? wdata[CTRL_PRESC +: PRESC_WIDTH] : presc;
            en       <= en_n;
            oneshot  <= wr_ctrl ? wdata[CTRL_ONESHOT] : oneshot;
            cmp_ie   <= cmp_ie_n;
            ovf_ie   <= ovf_ie_n;
            cmp_pend <= cmp_pend_n;
            ovf_pend <= ovf_pend_n;
            irq      <= (cmp_pend_n && cmp_ie_n) || (ovf_pend_n && ovf_ie_n);
        end
    end
    assign count_rd = 32'(count);
    assign cmp_rd   = 32'(cmp);
    always_comb begin
        ctrl_rd                            = '0;
        ctrl_rd[CTRL_EN]                   = en;
        ctrl_rd[CTRL_ONESHOT]              = oneshot;
        ctrl_rd[CTRL_CMP_IE]               = cmp_ie;
        ctrl_rd[CTRL_OVF_IE]               = ovf_ie;
        ctrl_rd[CTRL_PRESC +: PRESC_WIDTH] = presc;
        status_rd                          = '0;
        status_rd[ST_CMP]                  = cmp_pend;
        status_rd[ST_OVF]                  = ovf_pend;
    end
endmodule

// File: rtl/apb_timer_multi.sv
// apb_timer_multi: N-channel APB timer (APB slave on HCLK/HRESET, PSLVERR on unmapped access, one level irq_o per channel)
module apb_timer_multi
    import timer_multi_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_TIMERS       = 4,
    parameter int CNT_WIDTH      = 32,
    parameter int PRESC_WIDTH    = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [N_TIMERS-1:0]       irq_o
);
    logic        access, err, wr, rd, is_start, ch_bad, hi_bad;
    logic [2:0]  ch;
    logic [8:0]  off;
    logic [31:0] count_rd [N_TIMERS];
    logic [31:0] ctrl_rd [N_TIMERS];
    logic [31:0] cmp_rd [N_TIMERS];
    logic [31:0] status_rd [N_TIMERS];
    logic        unused_addr;
    assign access      = PSEL && PENABLE;
    assign ch          = PADDR[6:4];
    assign off         = {5'd0, PADDR[3:2], 2'b00};
    assign is_start    = PADDR[8:0] == REG_START;
    assign ch_bad      = {1'b0, ch} >= 4'(N_TIMERS);
    assign hi_bad      = (PADDR >> 9) != '0;
    assign err         = ch_bad || (PADDR[8] && !is_start) || hi_bad;
    assign PSLVERR     = access && err;
    assign PREADY      = 1'b1;
    assign wr          = access && PWRITE && !err;
    assign rd          = access && !PWRITE && !err;
    assign unused_addr = ^{PADDR[7], PADDR[1:0]};
    genvar c;
    generate
        for (c = 0; c < N_TIMERS; c++) begin : g_ch
            logic sel;
            assign sel = wr && !PADDR[8] && ch == 3'(c);
            timer_multi_channel #(
                .CNT_WIDTH  (CNT_WIDTH),
                .PRESC_WIDTH(PRESC_WIDTH)
            ) u_ch (
                .clk      (HCLK),
                .rst      (HRESET),
                .wr_count (sel && off == REG_COUNT),
                .wr_ctrl  (sel && off == REG_CTRL),
                .wr_cmp   (sel && off == REG_CMP),
                .wr_status(sel && off == REG_STATUS),
                .start    (wr && is_start && PWDATA[c]),
                .wdata    (PWDATA),
                .count_rd (count_rd[c]),
                .ctrl_rd  (ctrl_rd[c]),
                .cmp_rd   (cmp_rd[c]),
                .status_rd(status_rd[c]),
                .irq      (irq_o[c])
            );
        end
    endgenerate
    always_comb begin
        PRDATA = '0;
        for (int i = 0; i < N_TIMERS; i++)
            if (rd && !PADDR[8] && ch == 3'(i))
                PRDATA = off == REG_COUNT ? count_rd[i] : off == REG_CTRL ? ctrl_rd[i] : off == REG_CMP ? cmp_rd[i] : status_rd[i];
    end
endmodule

// File: tb/tb_apb_timer_multi.sv
// tb_apb_timer_multi: self-checking bench for apb_timer_multi (register table plus timed channel sequences)
module tb_apb_timer_multi;
    logic        HCLK = 1'b0;
    logic        HRESET, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [11:0] PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [3:0]  irq_o;
    int checks = 0;
    int errors = 0;
    typedef struct { string name; logic [31:0] rd; logic err; } exp_t;
    exp_t sb[$];
    typedef struct { logic wr; logic [11:0] a; logic [31:0] d; logic [31:0] rd; logic err; } vec_t;
    vec_t vt [20];
    logic [31:0] s1_seq [5];
    always #5 HCLK = ~HCLK;
    apb_timer_multi #(
        .APB_ADDR_WIDTH(12),
        .N_TIMERS      (4),
        .CNT_WIDTH     (8),
        .PRESC_WIDTH   (8)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .PADDR  (PADDR),
        .PWDATA (PWDATA),
        .PWRITE (PWRITE),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .irq_o  (irq_o)
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask
    task automatic xfer(input string n, input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] erd, input logic eerr);
        exp_t e;
        sb.push_back('{n, erd, eerr});
        PSEL = 1'b1;
        PENABLE = 1'b0;
        PWRITE = w;
        PADDR = a;
        PWDATA = d;
        @(posedge HCLK);
        #1;
        PENABLE = 1'b1;
        #1;
        e = sb.pop_front();
        chk({e.name, " prdata"}, PRDATA, e.rd);
        chk({e.name, " pslverr"}, 32'(PSLVERR), 32'(e.err));
        @(posedge HCLK);
        #1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
    endtask
    task automatic wr(input string n, input logic [11:0] a, input logic [31:0] d);
        xfer(n, 1'b1, a, d, 32'h0, 1'b0);
    endtask
    task automatic rd(input string n, input logic [11:0] a, input logic [31:0] exp);
        xfer(n, 1'b0, a, 32'h0, exp, 1'b0);
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        HRESET = 1'b1;
        PSEL = 1'b0;
        PENABLE = 1'b0;
        PWRITE = 1'b0;
        PADDR = '0;
        PWDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk("reset irq", 32'(irq_o), 32'h0);
        chk("idle prdata", PRDATA, 32'h0);
        chk("pready", 32'(PREADY), 32'h1);
        vt[0]  = '{1'b0, 12'h000, 32'h0,        32'h0,      1'b0};
        vt[1]  = '{1'b0, 12'h014, 32'h0,        32'h0,      1'b0};
        vt[2]  = '{1'b0, 12'h03C, 32'h0,        32'h0,      1'b0};
        vt[3]  = '{1'b1, 12'h008, 32'h123456AB, 32'h0,      1'b0};
        vt[4]  = '{1'b0, 12'h008, 32'h0,        32'hAB,     1'b0};
        vt[5]  = '{1'b1, 12'h004, 32'hFFFFFF0E, 32'h0,      1'b0};
        vt[6]  = '{1'b0, 12'h004, 32'h0,        32'hFF0E,   1'b0};
        vt[7]  = '{1'b1, 12'h000, 32'h1FF,      32'h0,      1'b0};
        vt[8]  = '{1'b0, 12'h000, 32'h0,        32'hFF,     1'b0};
        vt[9]  = '{1'b1, 12'h008, 32'h11,       32'h0,      1'b0};
        vt[10] = '{1'b0, 12'h000, 32'h0,        32'h0,      1'b0};
        vt[11] = '{1'b0, 12'h100, 32'h0,        32'h0,      1'b0};
        vt[12] = '{1'b0, 12'h050, 32'h0,        32'h0,      1'b1};
        vt[13] = '{1'b1, 12'h104, 32'hF,        32'h0,      1'b1};
        vt[14] = '{1'b1, 12'h050, 32'h55,       32'h0,      1'b1};
        vt[15] = '{1'b0, 12'h200, 32'h0,        32'h0,      1'b1};
        vt[16] = '{1'b0, 12'h180, 32'h0,        32'h0,      1'b1};
        vt[17] = '{1'b0, 12'h004, 32'h0,        32'hFF0E,   1'b0};
        vt[18] = '{1'b0, 12'h014, 32'h0,        32'h0,      1'b0};
        vt[19] = '{1'b1, 12'h004, 32'h0,        32'h0,      1'b0};
        for (int i = 0; i < 20; i++)
            xfer($sformatf("vec%0d", i), vt[i].wr, vt[i].a, vt[i].d, vt[i].rd, vt[i].err);
        rd("vec cmp kept", 12'h008, 32'h11);
        // continuous compare on ch0: CMP=4, PRESC=0
        wr("s1 cmp", 12'h008, 32'd4);
        wr("s1 ctrl", 12'h004, 32'h5);
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            chk($sformatf("s1 irq edge%0d", k), 32'(irq_o[0]), 32'(k == 5));
        end
        s1_seq = '{32'd1, 32'd3, 32'd0, 32'd2, 32'd4};
        for (int k = 0; k < 5; k++)
            rd($sformatf("s1 count%0d", k), 12'h000, s1_seq[k]);
        chk("s1 irq held", 32'(irq_o[0]), 32'h1);
        wr("s1 w1c", 12'h00C, 32'h1);
        chk("s1 irq cleared", 32'(irq_o[0]), 32'h0);
        wr("s1 stop", 12'h004, 32'h0);
        wr("s1 clr", 12'h00C, 32'h3);
        rd("s1 frozen", 12'h000, 32'd4);
        // one-shot with prescaler on ch1
        wr("s2 cmp", 12'h018, 32'd2);
        wr("s2 ctrl", 12'h014, 32'h207);
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            chk($sformatf("s2 irq edge%0d", k), 32'(irq_o[1]), 32'(k == 9));
        end
        rd("s2 ctrl en off", 12'h014, 32'h206);
        rd("s2 count", 12'h010, 32'h0);
        cyc(5);
        rd("s2 count still", 12'h010, 32'h0);
        rd("s2 status", 12'h01C, 32'h1);
        chk("s2 irq held", 32'(irq_o[1]), 32'h1);
        // overflow on ch2 with 8-bit counters
        wr("s3 count", 12'h020, 32'hFE);
        wr("s3 ctrl", 12'h024, 32'h9);
        chk("s3 irq before", 32'(irq_o[2]), 32'h0);
        rd("s3 count ff", 12'h020, 32'hFF);
        chk("s3 irq ovf", 32'(irq_o[2]), 32'h1);
        rd("s3 count wrap", 12'h020, 32'h1);
        rd("s3 status", 12'h02C, 32'h2);
        wr("s3 ie off", 12'h024, 32'h0);
        chk("s3 irq ie cleared", 32'(irq_o[2]), 32'h0);
        rd("s3 status kept", 12'h02C, 32'h2);
        wr("s3 clr", 12'h02C, 32'h3);
        // global start of ch0 and ch3
        wr("s4 ch0 cmp", 12'h008, 32'h0);
        wr("s4 ch3 ctrl", 12'h034, 32'h8);
        wr("s4 start", 12'h100, 32'hF9);
        rd("s4 ch0 c1", 12'h000, 32'd1);
        rd("s4 ch3 c3", 12'h030, 32'd3);
        rd("s4 ch0 c5", 12'h000, 32'd5);
        rd("s4 ch3 c7", 12'h030, 32'd7);
        rd("s4 ch0 ctrl", 12'h004, 32'h1);
        rd("s4 ch3 ctrl", 12'h034, 32'h9);
        rd("s4 ch1 ctrl", 12'h014, 32'h206);
        rd("s4 ch2 ctrl", 12'h024, 32'h0);
        chk("s4 irq", 32'(irq_o), 32'h2);
        wr("s4 ch0 stop", 12'h004, 32'h0);
        wr("s4 ch3 stop", 12'h034, 32'h0);
        // W1C colliding with a new compare match on ch0
        wr("s5 cmp", 12'h008, 32'd2);
        wr("s5 ctrl", 12'h004, 32'h5);
        cyc(4);
        wr("s5 w1c collide", 12'h00C, 32'h1);
        chk("s5 irq kept", 32'(irq_o[0]), 32'h1);
        rd("s5 status kept", 12'h00C, 32'h1);
        wr("s5 stop", 12'h004, 32'h4);
        wr("s5 w1c", 12'h00C, 32'h1);
        chk("s5 irq cleared", 32'(irq_o[0]), 32'h0);
        rd("s5 status cleared", 12'h00C, 32'h0);
        // reset while ch2 is counting
        wr("s6 count", 12'h020, 32'h10);
        wr("s6 ctrl", 12'h024, 32'h1);
        cyc(3);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk("s6 irq", 32'(irq_o), 32'h0);
        rd("s6 count", 12'h020, 32'h0);
        rd("s6 ctrl", 12'h024, 32'h0);
        rd("s6 ch1 status", 12'h01C, 32'h0);
        rd("s6 ch1 ctrl", 12'h014, 32'h0);
        cyc(3);
        rd("s6 count idle", 12'h020, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
